// File: rtl/fetch_unit.sv
// Instruction-fetch responder: one outstanding imem request, {pc, instr} FIFO toward decode.
// Optional FETCH_PERF_CNT_EN adds the perf_stall_cnt output (cycles with stall_f=1).
module fetch_unit #(
  parameter int          DEPTH = 2,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic        stall_f,
  input  logic        flush,
  input  logic        stall_d,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        valid_d,
  output logic [31:0] pc_d,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_stall_cnt,
`endif
  output logic [31:0] instr_d
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   addr_q;
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];
  logic          push, pop, issue;

  assign valid_d = (count_q != '0);
  assign pc_d    = valid_d ? pc_mem_q[rd_ptr_q[AW-1:0]]    : '0;
  assign instr_d = valid_d ? instr_mem_q[rd_ptr_q[AW-1:0]] : NOP;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    push      = (state_q == WAIT) && imem_rvalid && !flush;
    pop       = valid_d && !stall_d && !flush;
    // Room check ignores a same-cycle pop, so a pending response always fits.
    issue     = !reset && !flush &&
                ((state_q == IDLE) || (state_q != IDLE && imem_rvalid)) &&
                (({1'b0, count_q} + {{CW{1'b0}}, push}) < DEPTH_C);
    imem_req  = issue;
    imem_addr = issue ? pc_in : '0;
    stall_f   = reset ? 1'b1 : (flush ? 1'b0 : !issue);

    unique case (state_q)
      IDLE: if (issue) state_d = WAIT;
      WAIT: begin
        if (flush)            state_d = imem_rvalid ? IDLE : DROP;
        else if (imem_rvalid) state_d = issue ? WAIT : IDLE;
      end
      DROP: if (imem_rvalid) state_d = issue ? WAIT : IDLE;
      default: state_d = IDLE;
    endcase

    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Datapath storage carries no reset; valid_d/count gate its visibility.
  always_ff @(posedge clk) begin
    if (issue) addr_q <= pc_in;
    if (push) begin
      pc_mem_q[wr_ptr_q[AW-1:0]]    <= addr_q;
      instr_mem_q[wr_ptr_q[AW-1:0]] <= imem_rdata;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        perf_q <= '0;
    else if (stall_f) perf_q <= perf_q + 32'd1;
  end

  assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: hand-derived vector table, reset-mid-transaction sequence,
// and randomized traffic checked against a queue-based reference model.
module tb_fetch_unit;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_in = '0;
  logic        flush = 1'b0, stall_d = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall_f, imem_req, valid_d;
  logic [31:0] imem_addr, pc_d, instr_d;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .stall_f(stall_f), .flush(flush),
    .stall_d(stall_d), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .valid_d(valid_d),
    .pc_d(pc_d),
`ifdef FETCH_PERF_CNT_EN
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .instr_d(instr_d)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: a queue of {pc, instr} plus "request outstanding" and "response stale" flags.
  logic [63:0] mq[$];
  bit          m_out, m_stale;
  logic [31:0] m_addr, m_perf;
  bit          e_req, e_stall, e_valid, e_push;
  logic [31:0] e_addr, e_pc, e_instr;

  function automatic void model_eval();
    e_valid = (mq.size() > 0);
    e_pc    = e_valid ? mq[0][63:32] : 32'h0;
    e_instr = e_valid ? mq[0][31:0]  : NOP;
    e_push  = m_out && !m_stale && imem_rvalid && !flush;
    if (reset) e_req = 1'b0;
    else       e_req = !flush && (!m_out || imem_rvalid) && ((mq.size() + int'(e_push)) < DEPTH);
    e_addr  = e_req ? pc_in : 32'h0;
    e_stall = reset ? 1'b1 : (flush ? 1'b0 : !e_req);
  endfunction

  function automatic void model_edge();
    model_eval();
    if (reset) begin
      mq.delete();
      m_out = 0; m_stale = 0; m_perf = 0;
      return;
    end
    if (e_stall) m_perf = m_perf + 32'd1;
    if (flush) mq.delete();
    else begin
      if (e_valid && !stall_d) void'(mq.pop_front());
      if (e_push) mq.push_back({m_addr, imem_rdata});
    end
    if (e_req) begin
      m_out = 1; m_stale = 0; m_addr = pc_in;
    end else if (m_out && imem_rvalid) begin
      m_out = 0; m_stale = 0;
    end else if (m_out && flush) begin
      m_stale = 1;
    end
  endfunction

  task automatic model_check(input string tag);
    model_eval();
    chk({tag, ".req"},   {31'b0, imem_req}, {31'b0, e_req});
    chk({tag, ".addr"},  imem_addr, e_addr);
    chk({tag, ".stall"}, {31'b0, stall_f},  {31'b0, e_stall});
    chk({tag, ".valid"}, {31'b0, valid_d},  {31'b0, e_valid});
    chk({tag, ".pc_d"},  pc_d, e_pc);
    chk({tag, ".instr"}, instr_d, e_instr);
`ifdef FETCH_PERF_CNT_EN
    chk({tag, ".perf"},  perf_stall_cnt, m_perf);
`endif
  endtask

  task automatic drive(input logic [31:0] pc, input bit fl, input bit sd, input bit rv,
                       input logic [31:0] rd);
    @(negedge clk);
    pc_in = pc; flush = fl; stall_d = sd; imem_rvalid = rv; imem_rdata = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
  endtask

  typedef struct {
    logic [31:0] pc; bit fl; bit sd; bit rv; logic [31:0] rd;
    bit req; logic [31:0] addr; bit stl; bit vld; logic [31:0] pcd; logic [31:0] ins;
  } vec_t;

  vec_t tbl[24];

  initial begin
    m_out = 0; m_stale = 0; m_perf = 0; m_addr = 0;
    //           pc        fl sd rv rdata           req addr      stl vld pc_d      instr
    tbl[0]  = '{32'h000, 0, 0, 0, 32'h0,          1, 32'h000, 0, 0, 32'h0,   NOP};
    tbl[1]  = '{32'h004, 0, 0, 1, 32'h00500093,   1, 32'h004, 0, 0, 32'h0,   NOP};
    tbl[2]  = '{32'h008, 0, 0, 0, 32'h0,          0, 32'h000, 1, 1, 32'h0,   32'h00500093};
    tbl[3]  = '{32'h008, 0, 0, 0, 32'h0,          0, 32'h000, 1, 0, 32'h0,   NOP};
    tbl[4]  = '{32'h008, 0, 0, 0, 32'h0,          0, 32'h000, 1, 0, 32'h0,   NOP};
    tbl[5]  = '{32'h008, 0, 0, 1, 32'h00A00113,   1, 32'h008, 0, 0, 32'h0,   NOP};
    tbl[6]  = '{32'h00C, 0, 0, 0, 32'h0,          0, 32'h000, 1, 1, 32'h004, 32'h00A00113};
    tbl[7]  = '{32'h00C, 0, 1, 0, 32'h0,          0, 32'h000, 1, 0, 32'h0,   NOP};
    tbl[8]  = '{32'h00C, 0, 1, 1, 32'h3,          1, 32'h00C, 0, 0, 32'h0,   NOP};
    tbl[9]  = '{32'h010, 0, 1, 1, 32'h4,          0, 32'h000, 1, 1, 32'h008, 32'h3};
    tbl[10] = '{32'h010, 0, 1, 0, 32'h0,          0, 32'h000, 1, 1, 32'h008, 32'h3};
    tbl[11] = '{32'h010, 0, 1, 0, 32'h0,          0, 32'h000, 1, 1, 32'h008, 32'h3};
    tbl[12] = '{32'h010, 0, 0, 0, 32'h0,          0, 32'h000, 1, 1, 32'h008, 32'h3};
    tbl[13] = '{32'h010, 0, 0, 0, 32'h0,          1, 32'h010, 0, 1, 32'h00C, 32'h4};
    tbl[14] = '{32'h014, 0, 0, 0, 32'h0,          0, 32'h000, 1, 0, 32'h0,   NOP};
    tbl[15] = '{32'h100, 1, 0, 0, 32'h0,          0, 32'h000, 0, 0, 32'h0,   NOP};
    tbl[16] = '{32'h100, 0, 0, 0, 32'h0,          0, 32'h000, 1, 0, 32'h0,   NOP};
    tbl[17] = '{32'h100, 0, 0, 1, 32'h0000DEAD,   1, 32'h100, 0, 0, 32'h0,   NOP};
    tbl[18] = '{32'h104, 0, 0, 0, 32'h0,          0, 32'h000, 1, 0, 32'h0,   NOP};
    tbl[19] = '{32'h104, 0, 0, 1, 32'h00000513,   1, 32'h104, 0, 0, 32'h0,   NOP};
    tbl[20] = '{32'h108, 0, 1, 0, 32'h0,          0, 32'h000, 1, 1, 32'h100, 32'h00000513};
    tbl[21] = '{32'h200, 1, 0, 1, 32'h00000BAD,   0, 32'h000, 0, 1, 32'h100, 32'h00000513};
    tbl[22] = '{32'h200, 0, 0, 0, 32'h0,          1, 32'h200, 0, 0, 32'h0,   NOP};
    tbl[23] = '{32'h204, 0, 0, 1, 32'h00000077,   1, 32'h204, 0, 0, 32'h0,   NOP};

    // Reset held with memory idle.
    drive(32'h0, 0, 0, 0, 32'h0);
    chk("rst.stall", {31'b0, stall_f}, 32'd1);
    chk("rst.req",   {31'b0, imem_req}, 32'd0);
    chk("rst.addr",  imem_addr, 32'h0);
    chk("rst.valid", {31'b0, valid_d}, 32'd0);
    chk("rst.instr", instr_d, NOP);
    chk("rst.pc_d",  pc_d, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst.perf",  perf_stall_cnt, 32'h0);
`endif
    tick();
    #2 reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].pc, tbl[i].fl, tbl[i].sd, tbl[i].rv, tbl[i].rd);
      chk($sformatf("vec%0d.req", i),   {31'b0, imem_req}, {31'b0, tbl[i].req});
      chk($sformatf("vec%0d.addr", i),  imem_addr, tbl[i].addr);
      chk($sformatf("vec%0d.stall", i), {31'b0, stall_f}, {31'b0, tbl[i].stl});
      chk($sformatf("vec%0d.valid", i), {31'b0, valid_d}, {31'b0, tbl[i].vld});
      chk($sformatf("vec%0d.pc_d", i),  pc_d, tbl[i].pcd);
      chk($sformatf("vec%0d.instr", i), instr_d, tbl[i].ins);
`ifdef FETCH_PERF_CNT_EN
      chk($sformatf("vec%0d.perf", i),  perf_stall_cnt, m_perf);
`endif
      tick();
    end

    // Reset asserted mid-cycle with a request outstanding and an entry buffered.
    drive(32'h300, 0, 1, 0, 32'h0);
    model_check("pre_arst");
    #1 reset = 1'b1;
    #1;
    mq.delete(); m_out = 0; m_stale = 0; m_perf = 0;
    model_check("arst");
    tick();
    #2 reset = 1'b0;
    // Late response lands in IDLE and must be ignored.
    drive(32'h400, 0, 0, 1, 32'h99);
    model_check("idle_rv");
    chk("idle_rv.req_addr", imem_addr, 32'h400);
    tick();
    drive(32'h404, 0, 0, 0, 32'h0);
    model_check("after_idle_rv");
    chk("after_idle_rv.valid", {31'b0, valid_d}, 32'd0);
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      drive($urandom, ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0),
            $urandom_range(0, 1) == 1, $urandom);
      model_check($sformatf("rnd%0d", n));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
